// File: rtl/adc_conv_sequencer_if.sv
// Result handshake from the ADC sequencer to its consumer (audio/PWM path, LED logic).
interface adc_conv_sequencer_if #(
  parameter int unsigned W = 7
);
  logic [W-1:0] sample_out;
  logic         sample_valid;
  logic         sample_ready;

  modport master (
    output sample_out,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/adc_conv_sequencer.sv
// Frames delay-line ADC conversions via adc_reset, averages 2^AVG_LOG2 codes with
// round-half-up, and offers each result over valid/ready with sticky overrun.
module adc_conv_sequencer #(
  parameter int unsigned FINE_BITS     = 6,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CONV_CYCLES   = 64,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 adc_reset,
  input  logic [FINE_BITS:0]   adc_code,
  adc_conv_sequencer_if.master smp,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int unsigned W    = FINE_BITS + 1;
  localparam int unsigned AW   = W + AVG_LOG2 + 1;
  localparam int unsigned CW   = AVG_LOG2 + 1;
  localparam int unsigned MAXC = (SETTLE_CYCLES > CONV_CYCLES) ? SETTLE_CYCLES : CONV_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);
  localparam int unsigned RSH  = (AVG_LOG2 == 0) ? 0 : AVG_LOG2 - 1;

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] CONV_LAST   = TW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] N_CONV      = CW'(1 << AVG_LOG2);
  localparam logic [AW-1:0] ROUND       = (AVG_LOG2 == 0) ? '0 : AW'(1 << RSH);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CONVERT,
    CAPTURE,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adc_reset_q, adc_reset_d;
  logic [W-1:0]  sample_out_q, sample_out_d;
  logic          sample_valid_q, sample_valid_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] acc_sum;
  logic [AW-1:0] avg;
  logic          unused_avg_hi;

  always_comb begin
    state_d        = state_q;
    cyc_d          = cyc_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    acc_sum        = acc_q + AW'(adc_code);
    avg            = (acc_q + ROUND) >> AVG_LOG2;

    if (clr_overrun) overrun_d = 1'b0;
    if (sample_valid_q && smp.sample_ready) sample_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ARM;
          cyc_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
          cyc_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (cyc_q == SETTLE_LAST) begin
          state_d = CONVERT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      CONVERT: begin
        if (!enable) begin
          state_d = IDLE;
          cyc_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (cyc_q == CONV_LAST) begin
          state_d = CAPTURE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d   = acc_sum;
          cnt_d   = cnt_q + 1'b1;
          state_d = ((cnt_q + 1'b1) == N_CONV) ? DONE : ARM;
        end
        cyc_d = '0;
      end
      DONE: begin
        state_d = enable ? ARM : IDLE;
        cyc_d   = '0;
        acc_d   = '0;
        cnt_d   = '0;
        // Same-cycle consumption frees the slot, so the new result replaces it.
        if (!sample_valid_q || smp.sample_ready) begin
          sample_out_d   = avg[W-1:0];
          sample_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    adc_reset_d = !((state_d == CONVERT) || (state_d == CAPTURE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cyc_q          <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      adc_reset_q    <= 1'b1;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      adc_reset_q    <= adc_reset_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  // Averaged sum of full-scale codes never exceeds the code range; top bits are always zero.
  assign unused_avg_hi    = ^avg[AW-1:W];

  assign adc_reset        = adc_reset_q;
  assign smp.sample_out   = sample_out_q;
  assign smp.sample_valid = sample_valid_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench: one AVG_LOG2=0 instance for single-shot latency, one default instance
// for averaging, handshake, overrun, abort and async reset, with a result scoreboard.
module tb_adc_conv_sequencer;

  localparam int unsigned FB = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en, clr0, clr;
  logic [FB:0] code0, code;
  logic        adc_reset0, adc_reset, busy0, busy, ovr0, ovr;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [FB:0] exp_q[$];

  adc_conv_sequencer_if #(.W(FB + 1)) s0_if ();
  adc_conv_sequencer_if #(.W(FB + 1)) s_if ();

  adc_conv_sequencer #(
    .FINE_BITS(FB), .SETTLE_CYCLES(4), .CONV_CYCLES(64), .AVG_LOG2(0)
  ) dut0 (
    .clk(clk), .reset(rst), .enable(en0), .adc_reset(adc_reset0), .adc_code(code0),
    .smp(s0_if.master), .busy(busy0), .overrun(ovr0), .clr_overrun(clr0)
  );

  adc_conv_sequencer #(
    .FINE_BITS(FB), .SETTLE_CYCLES(4), .CONV_CYCLES(64), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .reset(rst), .enable(en), .adc_reset(adc_reset), .adc_code(code),
    .smp(s_if.master), .busy(busy), .overrun(ovr), .clr_overrun(clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return adc_reset;
      1:       return s_if.sample_valid;
      default: return ovr;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int budget, input string tag);
    int n = 0;
    while (get_sig(sel) !== val && n < budget) begin
      tick(1);
      n++;
    end
    if (get_sig(sel) !== val) chk({tag, "_timeout"}, {31'd0, get_sig(sel)}, {31'd0, val});
  endtask

  task automatic sb_check(input string tag);
    logic [FB:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    chk(tag, s_if.sample_out, e);
  endtask

  task automatic run_set(input logic [FB:0] c0, input logic [FB:0] c1, input logic [FB:0] c2,
                         input logic [FB:0] c3, input logic [FB:0] expv, input string tag);
    logic [FB:0] cs[4];
    int unsigned e0;
    cs = '{c0, c1, c2, c3};
    exp_q.push_back(expv);
    en = 1'b1;
    tick(1);
    e0 = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 1'b0, 20, {tag, "_conv_start"});
      code = cs[i];
      wait_for(0, 1'b1, 80, {tag, "_conv_end"});
    end
    wait_for(1, 1'b1, 10, {tag, "_valid"});
    chk({tag, "_latency"}, cyc - e0, 277);
    sb_check(tag);
    en = 1'b0;
    tick(2);
    chk({tag, "_consumed"}, s_if.sample_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int unsigned e0;
    int          lowcnt;

    rst = 1'b1; en0 = 1'b0; en = 1'b0; clr0 = 1'b0; clr = 1'b0;
    code0 = '0; code = '0;
    s0_if.sample_ready = 1'b1;
    s_if.sample_ready  = 1'b1;
    #1;
    chk("rst_adc_reset", adc_reset, 1);
    chk("rst_valid", s_if.sample_valid, 0);
    chk("rst_out", s_if.sample_out, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_busy", busy, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("idle_busy", busy, 0);
    chk("idle_adc_reset", adc_reset, 1);

    // Single conversion, no averaging
    code0 = 7'd37;
    en0 = 1'b1;
    tick(1);
    e0 = cyc;
    lowcnt = 0;
    for (int k = 1; k <= 69; k++) begin
      tick(1);
      if (adc_reset0 === 1'b0) lowcnt++;
    end
    chk("a0_low_len", lowcnt, 65);
    chk("a0_done_adc_reset", adc_reset0, 1);
    chk("a0_not_yet_valid", s0_if.sample_valid, 0);
    en0 = 1'b0;
    tick(1);
    chk("a0_latency", cyc - e0, 70);
    chk("a0_valid", s0_if.sample_valid, 1);
    chk("a0_out", s0_if.sample_out, 37);
    chk("a0_busy", busy0, 0);
    tick(1);
    chk("a0_consumed", s0_if.sample_valid, 0);

    // Averaging with round-half-up
    run_set(7'd10, 7'd11, 7'd11, 7'd12, 7'd11, "avg44");
    run_set(7'd10, 7'd10, 7'd10, 7'd11, 7'd10, "avg41");
    run_set(7'd127, 7'd127, 7'd127, 7'd127, 7'd127, "avg_full");
    run_set(7'd0, 7'd0, 7'd1, 7'd1, 7'd1, "avg_half_up");
    run_set(7'd0, 7'd0, 7'd0, 7'd1, 7'd0, "avg_below_half");

    // Abort mid-CONVERT after one captured conversion
    code = 7'd100;
    en = 1'b1;
    tick(1);
    wait_for(0, 1'b0, 20, "ab_c1");
    wait_for(0, 1'b1, 80, "ab_c1e");
    wait_for(0, 1'b0, 20, "ab_c2");
    tick(30);
    en = 1'b0;
    tick(1);
    chk("ab_adc_reset", adc_reset, 1);
    chk("ab_busy", busy, 0);
    chk("ab_valid", s_if.sample_valid, 0);
    tick(2);
    chk("ab_ovr", ovr, 0);
    run_set(7'd10, 7'd10, 7'd10, 7'd10, 7'd10, "reenable");

    // Overrun with stalled consumer
    s_if.sample_ready = 1'b0;
    code = 7'd20;
    exp_q.push_back(7'd20);
    en = 1'b1;
    tick(1);
    e0 = cyc;
    wait_for(1, 1'b1, 300, "ovr_first");
    chk("ovr_first_latency", cyc - e0, 277);
    sb_check("ovr_first");
    code = 7'd30;
    wait_for(2, 1'b1, 300, "ovr_set");
    chk("ovr_set_time", cyc - e0, 554);
    chk("ovr_held_out", s_if.sample_out, 20);
    chk("ovr_held_valid", s_if.sample_valid, 1);
    code = 7'd40;
    exp_q.push_back(7'd40);
    tick(3);
    chk("ovr_sticky", ovr, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("ovr_cleared", ovr, 0);
    while (cyc < e0 + 830) tick(1);
    chk("ovr_done3_adc_reset", adc_reset, 1);
    s_if.sample_ready = 1'b1;
    tick(1);
    chk("ovr_reload_valid", s_if.sample_valid, 1);
    sb_check("ovr_reload");
    chk("ovr_reload_no_ovr", ovr, 0);
    s_if.sample_ready = 1'b0;
    while (cyc < e0 + 1100) tick(1);
    clr = 1'b1;
    wait_for(2, 1'b1, 20, "setwins");
    chk("setwins_time", cyc - e0, 1108);
    chk("setwins_out", s_if.sample_out, 40);
    tick(1);
    chk("setwins_clear_next", ovr, 0);
    clr = 1'b0;
    en = 1'b0;
    s_if.sample_ready = 1'b1;
    tick(2);
    chk("ovr_drained", s_if.sample_valid, 0);

    // Async reset mid-CONVERT with valid and overrun set
    s_if.sample_ready = 1'b0;
    code = 7'd50;
    exp_q.push_back(7'd50);
    en = 1'b1;
    tick(1);
    wait_for(1, 1'b1, 300, "ar_first");
    sb_check("ar_first");
    wait_for(2, 1'b1, 300, "ar_ovr");
    wait_for(0, 1'b0, 20, "ar_conv");
    tick(10);
    chk("ar_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_adc_reset", adc_reset, 1);
    chk("ar_valid", s_if.sample_valid, 0);
    chk("ar_out", s_if.sample_out, 0);
    chk("ar_overrun", ovr, 0);
    chk("ar_busy", busy, 0);
    en = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("ar_post_busy", busy, 0);
    chk("ar_post_adc_reset", adc_reset, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
